// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready payload handshake bundle for pipe_stage_skid
//
// Ports (per modport):
//   master : drives valid/data, samples ready  (producer side of a link)
//   slave  : samples valid/data, drives ready  (consumer side of a link)
//   valid  : payload valid this cycle
//   data   : DATA_WIDTH-bit packed payload
//   ready  : consumer accepts this cycle; a transfer is valid && ready
interface pipe_stage_skid_if #(
   parameter int DATA_WIDTH = 157
);
   logic                  valid;
   logic [DATA_WIDTH-1:0] data;
   logic                  ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - handshaked pipeline register with two-entry skid buffer
//
// Ports:
//   clk           : rising-edge clock
//   reset         : synchronous, active-high; restores every register
//   up            : upstream link (slave); up.ready is in_ready, driven from a flop
//   dn            : downstream link (master); dn.valid/dn.data are out_valid/out_data, registered
//   flush         : squash all held entries on the next edge (payload registers keep contents)
//   occupancy     : held entries, 0/1/2, equal to the state encoding
//   stall_cnt     : saturating count of cycles with out_valid && !out_ready && !flush
//   stall_cnt_clr : synchronous clear of stall_cnt, wins over increment
module pipe_stage_skid #(
   parameter int                   DATA_WIDTH      = 157,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
   parameter int                   STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   pipe_stage_skid_if.slave           up,
   pipe_stage_skid_if.master          dn,
   input  logic                       flush,
   output logic [1:0]                 occupancy,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
   input  logic                       stall_cnt_clr
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state;
   logic                  main_valid;
   logic [DATA_WIDTH-1:0] main_data;
   logic                  skid_valid;
   logic [DATA_WIDTH-1:0] skid_data;

   logic in_ready;
   logic out_ready;
   logic in_xfer;
   logic out_xfer;

   // in_ready comes straight from the skid valid flop, so there is no
   // combinational path from out_ready or flush back upstream.
   assign in_ready  = ~skid_valid;
   assign out_ready = dn.ready;
   assign in_xfer   = up.valid & in_ready;
   assign out_xfer  = main_valid & out_ready;

   assign up.ready  = in_ready;
   assign dn.valid  = main_valid;
   assign dn.data   = main_data;
   assign occupancy = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= EMPTY;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= RESET_VALUE;
         skid_data  <= RESET_VALUE;
         stall_cnt  <= '0;
      end else begin
         if (flush) begin
            // Only the valid bits drop; payload registers keep stale data.
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
         end else begin
            case (state)
               EMPTY: begin
                  if (in_xfer) begin
                     main_data  <= up.data;
                     main_valid <= 1'b1;
                     state      <= BUSY;
                  end
               end
               BUSY: begin
                  if (in_xfer && out_xfer) begin
                     main_data <= up.data;
                  end else if (in_xfer) begin
                     // Downstream stalled: park the extra beat in skid.
                     skid_data  <= up.data;
                     skid_valid <= 1'b1;
                     state      <= FULL;
                  end else if (out_xfer) begin
                     main_valid <= 1'b0;
                     state      <= EMPTY;
                  end
               end
               FULL: begin
                  // in_ready is low here, so only the drain can happen.
                  if (out_xfer) begin
                     main_data  <= skid_data;
                     skid_valid <= 1'b0;
                     state      <= BUSY;
                  end
               end
               default: begin
                  state      <= EMPTY;
                  main_valid <= 1'b0;
                  skid_valid <= 1'b0;
               end
            endcase
         end

         if (stall_cnt_clr) begin
            stall_cnt <= '0;
         end else if (main_valid && !out_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;
   localparam int DW = 157;
   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          stall_cnt_clr;
   logic [1:0]    occupancy;
   logic [SW-1:0] stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   pipe_stage_skid_if #(.DATA_WIDTH(DW)) up_if ();
   pipe_stage_skid_if #(.DATA_WIDTH(DW)) dn_if ();

   pipe_stage_skid #(
      .DATA_WIDTH(DW),
      .RESET_VALUE('0),
      .STALL_CNT_WIDTH(SW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .up(up_if.slave),
      .dn(dn_if.master),
      .flush(flush),
      .occupancy(occupancy),
      .stall_cnt(stall_cnt),
      .stall_cnt_clr(stall_cnt_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          iv;
      logic [DW-1:0] idata;
      logic          ordy;
      logic          fl;
      logic          e_ov;
      logic [DW-1:0] e_data;
      logic          e_ir;
      logic [1:0]    e_occ;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ov, input logic [DW-1:0] d,
                            input logic ir, input logic [1:0] occ);
      check({tag, ".out_valid"}, DW'(dn_if.valid), DW'(ov));
      if (ov) check({tag, ".out_data"}, dn_if.data, d);
      check({tag, ".in_ready"}, DW'(up_if.ready), DW'(ir));
      check({tag, ".occupancy"}, DW'(occupancy), DW'(occ));
   endtask

   function automatic vec_t mk(input logic iv, input logic [DW-1:0] idata, input logic ordy,
                               input logic fl, input logic e_ov, input logic [DW-1:0] e_data,
                               input logic e_ir, input logic [1:0] e_occ);
      vec_t v;
      v.iv = iv; v.idata = idata; v.ordy = ordy; v.fl = fl;
      v.e_ov = e_ov; v.e_data = e_data; v.e_ir = e_ir; v.e_occ = e_occ;
      return v;
   endfunction

   initial begin
      // Backpressure/skid: A, B, C back-to-back, out_ready drops when A appears.
      vecs.push_back(mk(1, 'hA,  1, 0, 1, 'hA,  1, 2'd1));
      vecs.push_back(mk(1, 'hB,  0, 0, 1, 'hA,  0, 2'd2));
      vecs.push_back(mk(1, 'hC,  0, 0, 1, 'hA,  0, 2'd2));
      vecs.push_back(mk(1, 'hC,  1, 0, 1, 'hB,  1, 2'd1));
      vecs.push_back(mk(1, 'hC,  1, 0, 1, 'hC,  1, 2'd1));
      vecs.push_back(mk(0, 'h0,  1, 0, 0, 'hC,  1, 2'd0));
      // Flush while FULL with a concurrent input.
      vecs.push_back(mk(1, 'hD,  0, 0, 1, 'hD,  1, 2'd1));
      vecs.push_back(mk(1, 'hE,  0, 0, 1, 'hD,  0, 2'd2));
      vecs.push_back(mk(1, 'hF,  0, 1, 0, 'hD,  1, 2'd0));
      vecs.push_back(mk(0, 'h0,  1, 0, 0, 'hD,  1, 2'd0));
      // Flush while BUSY: input is dropped even though in_ready is high.
      vecs.push_back(mk(1, 'h11, 0, 0, 1, 'h11, 1, 2'd1));
      vecs.push_back(mk(1, 'h12, 1, 1, 0, 'h11, 1, 2'd0));
      vecs.push_back(mk(0, 'h0,  1, 0, 0, 'h11, 1, 2'd0));

      reset = 1'b1; flush = 1'b0; stall_cnt_clr = 1'b0;
      up_if.valid = 1'b1; up_if.data = DW'('h1234); dn_if.ready = 1'b0;

      // Reset
      tick(); tick();
      check("rst.out_valid", DW'(dn_if.valid), DW'(0));
      check("rst.in_ready", DW'(up_if.ready), DW'(1));
      check("rst.occupancy", DW'(occupancy), DW'(0));
      check("rst.out_data", dn_if.data, '0);
      check("rst.stall_cnt", DW'(stall_cnt), DW'(0));
      reset = 1'b0; up_if.valid = 1'b0;
      tick();
      check_all("idle", 0, '0, 1, 2'd0);

      // Streaming 0x01..0x10 with 1-cycle latency
      dn_if.ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         up_if.valid = 1'b1; up_if.data = DW'(i);
         tick();
         check_all($sformatf("stream%0d", i), 1, DW'(i), 1, 2'd1);
      end
      up_if.valid = 1'b0;
      tick();
      check_all("stream_end", 0, '0, 1, 2'd0);

      // Table-driven backpressure and flush vectors
      for (int i = 0; i < vecs.size(); i++) begin
         up_if.valid = vecs[i].iv; up_if.data = vecs[i].idata;
         dn_if.ready = vecs[i].ordy; flush = vecs[i].fl;
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_data, vecs[i].e_ir, vecs[i].e_occ);
      end
      flush = 1'b0;

      // Stall counter: clear wins over increment, exact count, then saturation.
      up_if.valid = 1'b1; up_if.data = DW'('h55); dn_if.ready = 1'b0;
      tick();
      up_if.valid = 1'b0; stall_cnt_clr = 1'b1;
      tick();
      check("stall.clr_prio", DW'(stall_cnt), DW'(0));
      stall_cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("stall.count5", DW'(stall_cnt), DW'(5));
      for (int i = 0; i < 69995; i++) tick();
      check("stall.saturate", DW'(stall_cnt), DW'('hFFFF));
      check_all("stall.held", 1, DW'('h55), 1, 2'd1);
      stall_cnt_clr = 1'b1;
      tick();
      check("stall.clr", DW'(stall_cnt), DW'(0));
      stall_cnt_clr = 1'b0;

      // Reset mid-stream while FULL
      up_if.valid = 1'b1; up_if.data = DW'('h66);
      tick();
      check_all("pre_rst", 1, DW'('h55), 0, 2'd2);
      reset = 1'b1; up_if.data = DW'('h77); dn_if.ready = 1'b1;
      tick();
      check("mrst.out_valid", DW'(dn_if.valid), DW'(0));
      check("mrst.in_ready", DW'(up_if.ready), DW'(1));
      check("mrst.occupancy", DW'(occupancy), DW'(0));
      check("mrst.out_data", dn_if.data, '0);
      check("mrst.stall_cnt", DW'(stall_cnt), DW'(0));
      reset = 1'b0; up_if.data = DW'('h88);
      tick();
      check_all("post_rst", 1, DW'('h88), 1, 2'd1);
      up_if.valid = 1'b0;
      tick();
      check_all("post_rst_drain", 0, '0, 1, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
